// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline stall/flush sequencer.
// Holds the sequencer state encoding, the hardwired-zero register and the ID_EX bubble controls.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Control bits ID_EX receives when a bubble is inserted.
   typedef struct packed {
      logic reg_write;
      logic mem_wr;
      logic mem_rd;
      logic branch;
   } idex_ctrl_t;

   localparam idex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers in ID.
// A load into r0 never creates a dependency because r0 is hardwired to zero.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       idex_memrd_i,
   input  logic [4:0] idex_rt_i,
   input  logic [4:0] ifid_rs_i,
   input  logic [4:0] ifid_rt_i,
   output logic       hazard_o
);

   assign hazard_o = idex_memrd_i && (idex_rt_i != REG_ZERO) &&
                     ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: load-use bubbles, branch flushes, data-memory freeze
// with a timeout watchdog, and saturating stall/flush counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
)
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             IDEX_MemRd_i,
   input  logic [4:0]       IDEX_Rt_i,
   input  logic [4:0]       IFID_Rs_i,
   input  logic [4:0]       IFID_Rt_i,
   input  logic             Branch_i,
   input  logic             DMem_req_i,
   input  logic             DMem_ack_i,
   output logic             PC_Wr_o,
   output logic             IFID_Wr_o,
   output logic             IFID_Flush_o,
   output logic             IDEX_Wr_o,
   output logic             IDEX_Bubble_o,
   output logic             EXMEM_Wr_o,
   output logic             MEMWB_Wr_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output state_t           state_o
);

   localparam int              WD_W     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MEM_TIMEOUT);

   state_t            state_q, state_d;
   logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
   logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d;
   logic              hazard, memstall, advance;

   hazard_detect u_hazard_detect (
      .idex_memrd_i (IDEX_MemRd_i),
      .idex_rt_i    (IDEX_Rt_i),
      .ifid_rs_i    (IFID_Rs_i),
      .ifid_rt_i    (IFID_Rt_i),
      .hazard_o     (hazard)
   );

   // The MEM stage raises req for an access; the access is done in the first cycle ack is high,
   // which may be the request cycle itself, so only req without ack freezes the pipeline.
   assign memstall = DMem_req_i & ~DMem_ack_i;
   assign wd_inc   = wd_q + 1'b1;

   always_comb begin
      state_d = state_q;
      wd_d    = wd_q;
      advance = 1'b0;
      unique case (state_q)
         RUN: begin
            if (memstall) begin
               state_d = MEM_WAIT;
               wd_d    = WD_W'(1);
            end else begin
               advance = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (DMem_ack_i) begin
               advance = 1'b1;
               state_d = RUN;
               wd_d    = '0;
            end else begin
               wd_d = wd_inc;
               if (wd_inc == WD_LIMIT) state_d = ERR;
            end
         end
         ERR: ;
         default: state_d = RUN;
      endcase
   end

   // A bubble or flush is only raised alongside the write enable of the register it targets.
   always_comb begin
      PC_Wr_o       = 1'b0;
      IFID_Wr_o     = 1'b0;
      IFID_Flush_o  = 1'b0;
      IDEX_Wr_o     = 1'b0;
      IDEX_Bubble_o = 1'b0;
      EXMEM_Wr_o    = 1'b0;
      MEMWB_Wr_o    = 1'b0;
      if (advance && !rst_i) begin
         PC_Wr_o    = 1'b1;
         IFID_Wr_o  = 1'b1;
         IDEX_Wr_o  = 1'b1;
         EXMEM_Wr_o = 1'b1;
         MEMWB_Wr_o = 1'b1;
         if (hazard) begin
            PC_Wr_o       = 1'b0;
            IFID_Wr_o     = 1'b0;
            IDEX_Bubble_o = 1'b1;
         end else if (Branch_i) begin
            IFID_Flush_o = 1'b1;
         end
      end
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (!PC_Wr_o && (stall_q != '1)) stall_d = stall_q + 1'b1;
      if (IFID_Flush_o && (flush_q != '1)) flush_d = flush_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RUN;
         wd_q    <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign err_o       = (state_q == ERR);
   assign stall_cnt_o = stall_q;
   assign flush_cnt_o = flush_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for the single-cycle rules,
// hand-written sequences for the memory timeout, counter saturation and mid-cycle reset.
module tb_pipeline_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int TO = 8;
   localparam int CW = 4;

   // Output word order: {pc, ifid, flush, idex, bubble, exmem, memwb, err}
   localparam logic [7:0] O_RUN   = 8'b1101_0110;
   localparam logic [7:0] O_HAZ   = 8'b0001_1110;
   localparam logic [7:0] O_FLUSH = 8'b1111_0110;
   localparam logic [7:0] O_STALL = 8'b0000_0000;
   localparam logic [7:0] O_ERR   = 8'b0000_0001;

   logic          clk = 1'b0;
   logic          rst;
   logic          memrd, br, req, ack;
   logic [4:0]    idex_rt, rs, rt;
   logic          pc_wr, ifid_wr, ifid_flush, idex_wr, idex_bub, exmem_wr, memwb_wr, err;
   logic [CW-1:0] stall_cnt, flush_cnt;
   state_t        state;
   logic [7:0]    outs;

   int n_chk  = 0;
   int n_fail = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic       memrd;
      logic [4:0] idex_rt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       br;
      logic       req;
      logic       ack;
      logic [7:0] exp_o;
      int         exp_s;
      int         exp_f;
   } vec_t;

   vec_t vecs[18];

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .IDEX_MemRd_i  (memrd),
      .IDEX_Rt_i     (idex_rt),
      .IFID_Rs_i     (rs),
      .IFID_Rt_i     (rt),
      .Branch_i      (br),
      .DMem_req_i    (req),
      .DMem_ack_i    (ack),
      .PC_Wr_o       (pc_wr),
      .IFID_Wr_o     (ifid_wr),
      .IFID_Flush_o  (ifid_flush),
      .IDEX_Wr_o     (idex_wr),
      .IDEX_Bubble_o (idex_bub),
      .EXMEM_Wr_o    (exmem_wr),
      .MEMWB_Wr_o    (memwb_wr),
      .err_o         (err),
      .stall_cnt_o   (stall_cnt),
      .flush_cnt_o   (flush_cnt),
      .state_o       (state)
   );

   assign outs = {pc_wr, ifid_wr, ifid_flush, idex_wr, idex_bub, exmem_wr, memwb_wr, err};

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic m, input int irt, input int s1, input int s2,
                               input logic b, input logic rq, input logic ak,
                               input logic [7:0] eo, input int es, input int ef);
      vec_t v;
      v.memrd = m; v.idex_rt = 5'(irt); v.rs = 5'(s1); v.rt = 5'(s2);
      v.br = b; v.req = rq; v.ack = ak; v.exp_o = eo; v.exp_s = es; v.exp_f = ef;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic m, input int irt, input int s1, input int s2,
                        input logic b, input logic rq, input logic ak);
      memrd = m; idex_rt = 5'(irt); rs = 5'(s1); rt = 5'(s2); br = b; req = rq; ack = ak;
   endtask

   task automatic idle();
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   // Called at posedge+1: apply, check combinational outputs mid-cycle, then counters after the edge.
   task automatic step(input vec_t v, input int idx);
      drive(v.memrd, int'(v.idex_rt), int'(v.rs), int'(v.rt), v.br, v.req, v.ack);
      exp_q.push_back(v.exp_o);
      #3;
      chk("outs", idx, 32'(outs), 32'(exp_q.pop_front()));
      @(posedge clk); #1;
      chk("stall_cnt", idx, 32'(stall_cnt), 32'(v.exp_s));
      chk("flush_cnt", idx, 32'(flush_cnt), 32'(v.exp_f));
   endtask

   initial begin
      //             memrd rt  rs  rt  br    req   ack   outs     s  f
      vecs[0]  = mk(1'b0, 0,  0,  0, 1'b0, 1'b0, 1'b0, O_RUN,   0, 0);
      vecs[1]  = mk(1'b1, 8,  8,  2, 1'b0, 1'b0, 1'b0, O_HAZ,   1, 0);
      vecs[2]  = mk(1'b0, 0,  8,  2, 1'b0, 1'b0, 1'b0, O_RUN,   1, 0);
      vecs[3]  = mk(1'b1, 0,  0,  0, 1'b0, 1'b0, 1'b0, O_RUN,   1, 0);
      vecs[4]  = mk(1'b1, 8,  3,  9, 1'b0, 1'b0, 1'b0, O_RUN,   1, 0);
      vecs[5]  = mk(1'b1, 8,  1,  8, 1'b0, 1'b0, 1'b0, O_HAZ,   2, 0);
      vecs[6]  = mk(1'b0, 0,  4,  5, 1'b1, 1'b0, 1'b0, O_FLUSH, 2, 1);
      vecs[7]  = mk(1'b1, 5,  5,  6, 1'b1, 1'b0, 1'b0, O_HAZ,   3, 1);
      vecs[8]  = mk(1'b0, 0,  5,  6, 1'b1, 1'b0, 1'b0, O_FLUSH, 3, 2);
      vecs[9]  = mk(1'b0, 0,  0,  0, 1'b0, 1'b1, 1'b1, O_RUN,   3, 2);
      vecs[10] = mk(1'b0, 0,  0,  0, 1'b1, 1'b1, 1'b1, O_FLUSH, 3, 3);
      vecs[11] = mk(1'b1, 7,  7,  0, 1'b1, 1'b1, 1'b0, O_STALL, 4, 3);
      vecs[12] = mk(1'b0, 0,  0,  0, 1'b0, 1'b1, 1'b0, O_STALL, 5, 3);
      vecs[13] = mk(1'b0, 0,  0,  0, 1'b1, 1'b1, 1'b0, O_STALL, 6, 3);
      vecs[14] = mk(1'b0, 0,  0,  0, 1'b0, 1'b1, 1'b0, O_STALL, 7, 3);
      vecs[15] = mk(1'b0, 0,  0,  0, 1'b0, 1'b0, 1'b0, O_STALL, 8, 3);
      vecs[16] = mk(1'b1, 4,  4,  0, 1'b0, 1'b1, 1'b1, O_HAZ,   9, 3);
      vecs[17] = mk(1'b0, 0,  0,  0, 1'b0, 1'b0, 1'b1, O_RUN,   9, 3);

      // Reset with busy inputs: every control output must be low.
      rst = 1'b1;
      drive(1'b1, 8, 8, 8, 1'b1, 1'b1, 1'b0);
      #2;
      chk("reset_outs", 0, 32'(outs), 32'(O_STALL));
      chk("reset_stall", 0, 32'(stall_cnt), 32'd0);
      chk("reset_flush", 0, 32'(flush_cnt), 32'd0);
      chk("reset_state", 0, 32'(state), 32'(RUN));
      idle();
      #10 rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 18; i++) step(vecs[i], i);
      chk("state_after_table", 0, 32'(state), 32'(RUN));

      // Timeout: one RUN stall cycle plus seven MEM_WAIT cycles, then ERR.
      drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < TO; i++) begin
         #3;
         chk("to_pc_wr", i, 32'(pc_wr), 32'd0);
         chk("to_err", i, 32'(err), 32'd0);
         @(posedge clk); #1;
         chk("to_state", i, 32'(state), (i < TO - 1) ? 32'(MEM_WAIT) : 32'(ERR));
         chk("to_stall", i, 32'(stall_cnt), (9 + i + 1 > 15) ? 32'd15 : 32'(9 + i + 1));
      end
      // ERR ignores ack and branch; stall counter stays saturated.
      drive(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         #3;
         chk("err_outs", i, 32'(outs), 32'(O_ERR));
         @(posedge clk); #1;
         chk("err_stall_sat", i, 32'(stall_cnt), 32'd15);
         chk("err_flush", i, 32'(flush_cnt), 32'd3);
      end
      #($urandom_range(1, 3));
      rst = 1'b1;
      #1;
      chk("err_rst_outs", 0, 32'(outs), 32'(O_STALL));
      chk("err_rst_state", 0, 32'(state), 32'(RUN));
      chk("err_rst_stall", 0, 32'(stall_cnt), 32'd0);
      chk("err_rst_flush", 0, 32'(flush_cnt), 32'd0);
      idle();
      #2 rst = 1'b0;
      @(posedge clk); #1;
      #3;
      chk("post_err_outs", 0, 32'(outs), 32'(O_RUN));
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a MEM_WAIT cycle.
      drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("mw_state", 0, 32'(state), 32'(MEM_WAIT));
      chk("mw_outs", 0, 32'(outs), 32'(O_STALL));
      chk("mw_stall", 0, 32'(stall_cnt), 32'd1);
      #($urandom_range(1, 3));
      rst = 1'b1;
      #1;
      chk("mw_rst_outs", 0, 32'(outs), 32'(O_STALL));
      chk("mw_rst_state", 0, 32'(state), 32'(RUN));
      chk("mw_rst_stall", 0, 32'(stall_cnt), 32'd0);
      idle();
      #2 rst = 1'b0;
      @(posedge clk); #1;
      #3;
      chk("mw_post_outs", 0, 32'(outs), 32'(O_RUN));
      chk("mw_post_state", 0, 32'(state), 32'(RUN));
      @(posedge clk); #1;
      chk("mw_post_stall", 0, 32'(stall_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
